// File: rtl/intersection_scheduler.sv
// Two-phase (NS/EW) intersection sequencer with all-red clearance, loadable
// green times and pedestrian-driven early termination of the conflicting green.
`default_nettype none

module intersection_scheduler #(
    parameter int TIME_W     = 5,
    parameter int CLEAR_TIME = 2,
    parameter int MIN_GREEN  = 3,
    parameter int DEF_GREEN  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       is_running,
    input  logic       inst_send,
    input  logic       phase_sel,
    input  logic [3:0] input_time,
    input  logic [1:0] ped_req,
    output logic [3:0] light_green,
    output logic [2:0] phase_state,
    output logic [1:0] ped_ack
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        NS_GREEN = 3'd1,
        NS_CLEAR = 3'd2,
        EW_GREEN = 3'd3,
        EW_CLEAR = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   cnt_q, cnt_d;
    logic [TIME_W-1:0]   ns_time_q, ns_time_d;
    logic [TIME_W-1:0]   ew_time_q, ew_time_d;
    logic [1:0]          pend_q, pend_d;
    logic [1:0]          ack_q, ack_d;
    logic [3:0]          light_q, light_d;

    logic [TIME_W:0]     cnt_inc;
    logic [TIME_W-1:0]   dur;
    logic [TIME_W-1:0]   load_val;
    logic                min_met;
    logic                done;

    // Extra bit on the increment keeps the >= compare safe when a time shrinks.
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
    assign load_val = (input_time == 4'd0) ? TIME_W'(1) : TIME_W'(input_time);
    assign min_met  = (cnt_inc >= (TIME_W+1)'(MIN_GREEN));

    always_comb begin
        case (state_q)
            NS_GREEN: dur = ns_time_q;
            EW_GREEN: dur = ew_time_q;
            default:  dur = TIME_W'(CLEAR_TIME);
        endcase
    end

    assign done = (cnt_inc >= {1'b0, dur});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ns_time_d = ns_time_q;
        ew_time_d = ew_time_q;
        pend_d    = pend_q;
        ack_d     = 2'b00;
        light_d   = 4'b0000;

        if (inst_send) begin
            if (phase_sel) ew_time_d = load_val;
            else           ns_time_d = load_val;
        end

        if (!is_running) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    state_d = NS_GREEN;
                    cnt_d   = '0;
                end
                NS_GREEN: begin
                    if (done || (pend_q[1] && min_met)) begin
                        state_d = NS_CLEAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[TIME_W-1:0];
                    end
                end
                EW_GREEN: begin
                    if (done || (pend_q[0] && min_met)) begin
                        state_d = EW_CLEAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[TIME_W-1:0];
                    end
                end
                NS_CLEAR, EW_CLEAR: begin
                    if (done) begin
                        state_d = (state_q == NS_CLEAR) ? EW_GREEN : NS_GREEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[TIME_W-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A request for the phase already green is served on the spot.
        if (state_d == NS_GREEN && state_q != NS_GREEN) begin
            pend_d[0] = 1'b0;
            ack_d[0]  = 1'b1;
        end else if (ped_req[0]) begin
            if (state_q == NS_GREEN) ack_d[0]  = 1'b1;
            else                     pend_d[0] = 1'b1;
        end

        if (state_d == EW_GREEN && state_q != EW_GREEN) begin
            pend_d[1] = 1'b0;
            ack_d[1]  = 1'b1;
        end else if (ped_req[1]) begin
            if (state_q == EW_GREEN) ack_d[1]  = 1'b1;
            else                     pend_d[1] = 1'b1;
        end

        case (state_d)
            NS_GREEN: light_d = 4'b0101;
            EW_GREEN: light_d = 4'b1010;
            default:  light_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ns_time_q <= TIME_W'(DEF_GREEN);
            ew_time_q <= TIME_W'(DEF_GREEN);
            pend_q    <= 2'b00;
            ack_q     <= 2'b00;
            light_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ns_time_q <= ns_time_d;
            ew_time_q <= ew_time_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            light_q   <= light_d;
        end
    end

    assign light_green = light_q;
    assign phase_state = state_q;
    assign ped_ack     = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
// Randomized self-checking bench for intersection_scheduler against a
// phase/elapsed-tick reference model, plus light-exclusion and clearance checks.
`default_nettype none

module tb_intersection_scheduler;

    localparam int CLEAR = 2;
    localparam int MING  = 3;
    localparam int DEFG  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       is_running = 1'b0;
    logic       inst_send = 1'b0;
    logic       phase_sel = 1'b0;
    logic [3:0] input_time = 4'd0;
    logic [1:0] ped_req = 2'b00;
    logic [3:0] light_green;
    logic [2:0] phase_state;
    logic [1:0] ped_ack;

    intersection_scheduler #(
        .TIME_W(5), .CLEAR_TIME(CLEAR), .MIN_GREEN(MING), .DEF_GREEN(DEFG)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .is_running(is_running),
        .inst_send(inst_send), .phase_sel(phase_sel), .input_time(input_time),
        .ped_req(ped_req), .light_green(light_green), .phase_state(phase_state),
        .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 NS green, 2 NS clear, 3 EW green, 4 EW clear.
    int m_phase, m_elapsed;
    int m_time [2];
    bit m_pend [2];
    int m_ack, m_light;
    bit m_valid = 0;
    int last_grp = -1;
    int red_ticks = 0;

    function automatic int green_of(input int ph);
        return (ph == 1) ? 0 : (ph == 3) ? 1 : -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (tick && light_green == 4'b0000) red_ticks++;
            if (rst) begin
                m_phase = 0; m_elapsed = 0;
                m_time[0] = DEFG; m_time[1] = DEFG;
                m_pend[0] = 0; m_pend[1] = 0;
                m_ack = 0; m_light = 0;
                m_valid = 1;
                last_grp = -1;
            end else if (m_valid) begin
                int nxt, nel, g, limit, eg;
                bit cut;
                nxt = m_phase; nel = m_elapsed;
                g = green_of(m_phase);
                if (!is_running) begin
                    nxt = 0; nel = 0;
                end else if (tick) begin
                    if (m_phase == 0) begin
                        nxt = 1; nel = 0;
                    end else begin
                        limit = (g >= 0) ? m_time[g] : CLEAR;
                        cut = (g >= 0) && m_pend[1-g] && (m_elapsed + 1 >= MING);
                        if (cut || m_elapsed + 1 >= limit) begin
                            nxt = (m_phase % 4) + 1; nel = 0;
                        end else begin
                            nel = m_elapsed + 1;
                        end
                    end
                end
                eg = (nxt != m_phase) ? green_of(nxt) : -1;
                m_ack = 0;
                for (int p = 0; p < 2; p++) begin
                    if (eg == p) begin
                        m_pend[p] = 0; m_ack |= (1 << p);
                    end else if (ped_req[p]) begin
                        if (g == p) m_ack |= (1 << p);
                        else        m_pend[p] = 1;
                    end
                end
                if (inst_send) m_time[phase_sel] = (input_time == 0) ? 1 : int'(input_time);
                m_phase = nxt; m_elapsed = nel;
                m_light = (nxt == 1) ? 5 : (nxt == 3) ? 10 : 0;
            end
            #1;
            if (m_valid) begin
                int cg;
                chk("light", light_green, m_light);
                chk("state", phase_state, m_phase);
                chk("ack", ped_ack, m_ack);
                chk("excl", int'((light_green & 4'b0101) != 0 && (light_green & 4'b1010) != 0), 0);
                cg = (light_green == 4'b0101) ? 0 : (light_green == 4'b1010) ? 1 : -1;
                if (rst || phase_state == 3'd0) begin
                    last_grp = -1;
                end else if (cg >= 0) begin
                    if (last_grp >= 0 && cg != last_grp)
                        chk("clear_ticks", int'(red_ticks >= CLEAR), 1);
                    last_grp = cg;
                    red_ticks = 0;
                end
            end
        end
    end

    // Stimulus
    int  cyc = 0;
    bit  rnd_tick = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            tick = rnd_tick ? ($urandom_range(3) == 0) : (cyc % 4 == 0);
        end
    endtask

    task automatic wait_state(input int s);
        int k = 0;
        while (int'(phase_state) != s && k < 500) begin
            step(1);
            k++;
        end
        chk("wait_state", int'(phase_state), s);
    endtask

    task automatic load(input bit sel, input int t);
        inst_send = 1'b1; phase_sel = sel; input_time = 4'(t);
        step(1);
        inst_send = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_light", light_green, 0);
        chk("rst_state", phase_state, 0);
        chk("rst_ack", ped_ack, 0);
        is_running = 1'b1;
        step(4 * 60);

        wait_state(1);
        load(1'b1, 3);
        load(1'b0, 0);
        step(4 * 40);

        load(1'b0, 10);
        wait_state(2);
        wait_state(1);
        ped_req = 2'b10;
        step(1);
        ped_req = 2'b00;
        step(4 * 30);

        wait_state(2);
        wait_state(1);
        step(8);
        ped_req = 2'b01;
        step(1);
        ped_req = 2'b00;
        step(4 * 30);

        wait_state(3);
        step(4 * 5);
        is_running = 1'b0;
        step(6);
        is_running = 1'b1;
        step(4 * 20);

        load(1'b1, 3);
        wait_state(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(4 * 50);

        rnd_tick = 1;
        for (int i = 0; i < 4000; i++) begin
            ped_req    = ($urandom_range(19) == 0) ? 2'($urandom) : 2'b00;
            inst_send  = ($urandom_range(29) == 0);
            phase_sel  = 1'($urandom);
            input_time = 4'($urandom);
            if ($urandom_range(299) == 0) is_running = ~is_running;
            else if (!is_running && $urandom_range(7) == 0) is_running = 1'b1;
            rst = ($urandom_range(799) == 0);
            step(1);
        end
        inst_send = 1'b0; ped_req = 2'b00; rst = 1'b0;
        step(10);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
